// File: rtl/bcd_seconds_counter_if.sv
// Run control and BCD time reading shared between the stopwatch controller
// and the seconds counter.
interface bcd_seconds_counter_if;
  logic       count_enabled;
  logic [7:0] time_reading;

  modport master (output count_enabled, input  time_reading);
  modport slave  (input  count_enabled, output time_reading);
endinterface : bcd_seconds_counter_if

// File: rtl/bcd_seconds_counter.sv
// Two-digit BCD seconds counter: a prescaler divides clk down to a 1 s tick,
// and each tick advances a packed BCD value 00..99 with wrap to 00.
module bcd_seconds_counter #(
  parameter int unsigned CLK_FREQ = 100000000
) (
  input  logic                  clk,
  input  logic                  init_regs,
  bcd_seconds_counter_if.slave  bus
);

  localparam int unsigned PRESC_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ - 1);
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [3:0]         ones_q,  ones_d;
  logic [3:0]         tens_q,  tens_d;

  // Next-state: advance prescaler while enabled, ripple a tick into the digits.
  always_comb begin
    presc_d = presc_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    if (bus.count_enabled) begin
      if (presc_q != PRESC_MAX) begin
        presc_d = presc_q + PRESC_W'(1);
      end else begin
        presc_d = '0;
        if (ones_q != DIGIT_MAX) begin
          ones_d = ones_q + 4'd1;
        end else begin
          ones_d = 4'd0;
          tens_d = (tens_q != DIGIT_MAX) ? tens_q + 4'd1 : 4'd0;
        end
      end
    end
  end

  // Synchronous reset dominates enable and drops any partial second.
  always_ff @(posedge clk) begin
    if (init_regs) begin
      presc_q <= '0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
    end else begin
      presc_q <= presc_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
    end
  end

  assign bus.time_reading = {tens_q, ones_q};

endmodule : bcd_seconds_counter

// File: tb/tb_bcd_seconds_counter.sv
// Scoreboard bench: expected readings come from a count of enabled edges since
// the last reset, divided by CLK_FREQ and folded mod 100 into BCD.
module tb_bcd_seconds_counter;

  localparam int unsigned CLK_FREQ = 10;

  logic clk;
  logic init_regs;
  bcd_seconds_counter_if bus ();

  bcd_seconds_counter #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk       (clk),
    .init_regs (init_regs),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned enabled_edges = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  last_seen;

  function automatic logic [7:0] to_bcd(input int unsigned edges);
    int unsigned secs;
    secs = (edges / CLK_FREQ) % 100;
    return {4'(secs / 10), 4'(secs % 10)};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one edge's inputs, push the model's prediction, compare after the edge.
  task automatic step(input logic rst, input logic en, input string tag);
    logic [7:0] exp;
    @(negedge clk);
    init_regs         = rst;
    bus.count_enabled = en;
    if (rst)     enabled_edges = 0;
    else if (en) enabled_edges++;
    exp_q.push_back(to_bcd(enabled_edges));
    @(posedge clk);
    #1;
    last_seen = bus.time_reading;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, last_seen, exp);
    end
  endtask

  task automatic run(input int unsigned n, input logic en, input string tag);
    for (int i = 0; i < int'(n); i++) step(1'b0, en, tag);
  endtask

  initial begin
    init_regs         = 1'b1;
    bus.count_enabled = 1'b1;
    last_seen         = '0;

    // Reset held two cycles while enabled.
    step(1'b1, 1'b1, "reset0");
    step(1'b1, 1'b1, "reset1");
    check_eq("reset_val", last_seen, 8'h00);

    // 09 -> 10 carry lands exactly on the 100th enabled edge.
    run(99, 1'b1, "run_to_09");
    check_eq("pre_carry", last_seen, 8'h09);
    step(1'b0, 1'b1, "carry");
    check_eq("carry_10", last_seen, 8'h10);

    // Up to 99, then wrap.
    run(890, 1'b1, "run_to_99");
    check_eq("at_99", last_seen, 8'h99);
    run(9, 1'b1, "hold_99");
    check_eq("still_99", last_seen, 8'h99);
    step(1'b0, 1'b1, "wrap");
    check_eq("wrap_00", last_seen, 8'h00);

    // Pause retains the partial second.
    step(1'b1, 1'b1, "reset_pause");
    run(5, 1'b1, "pre_pause");
    run(20, 1'b0, "paused");
    run(4, 1'b1, "resume");
    check_eq("resume_hold", last_seen, 8'h00);
    step(1'b0, 1'b1, "resume_tick");
    check_eq("resume_01", last_seen, 8'h01);

    // Reset mid-count at 37 with enable high.
    step(1'b1, 1'b1, "reset_37");
    run(375, 1'b1, "run_to_37");
    check_eq("at_37", last_seen, 8'h37);
    step(1'b1, 1'b1, "reset_over_en");
    check_eq("reset_prio", last_seen, 8'h00);
    run(9, 1'b1, "post_reset");
    check_eq("post_reset_hold", last_seen, 8'h00);
    step(1'b0, 1'b1, "post_reset_tick");
    check_eq("post_reset_01", last_seen, 8'h01);

    // Random enable toggling.
    for (int i = 0; i < 5000; i++) step(1'b0, 1'($urandom_range(0, 1)), "random");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bcd_seconds_counter
